// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, state type and helpers for the UART command decoder
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_SETBG  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REG,
        ST_CHK
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// rtl/cmd_timeout.sv - clearable idle-cycle counter with a single-cycle expiry strobe
module cmd_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear in the expiry cycle suppresses the strobe so an arriving word always wins.
    assign expire_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - framed command packet decoder; UART_CMD_CHECKSUM_EN adds an XOR trailer word
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       word_data,
    input  logic              word_valid,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wdata,
    output logic [31:0]       bg_color,
    output logic              busy,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [7:0]        err_cnt
);

`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_t            state_q;
    logic [15:0]       rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       csum_q;
    logic [31:0]       bg_pend_q;
    logic              bg_pend_q_vld;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [31:0]       fb_wdata_q;
    logic [31:0]       bg_color_q;
    logic              pkt_done_q;
    logic              pkt_err_q;
    logic [7:0]        err_cnt_q;
    logic              tmo_expire;

    cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .en_i     (state_q != ST_IDLE),
        .clr_i    (word_valid),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            addr_q        <= '0;
            csum_q        <= '0;
            bg_pend_q     <= '0;
            bg_pend_q_vld <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
            bg_color_q    <= '0;
            pkt_done_q    <= 1'b0;
            pkt_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            fb_we_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            if (word_valid) begin
                csum_q <= csum_q ^ word_data;
                unique case (state_q)
                    ST_IDLE: begin
                        csum_q        <= word_data;
                        rem_q         <= word_data[15:0];
                        bg_pend_q_vld <= 1'b0;
                        if (word_data[31:24] != SYNC_BYTE) begin
                            pkt_err_q <= 1'b1;
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end else if (word_data[23:16] == OP_WRITE) begin
                            state_q <= ST_ADDR;
                        end else if (word_data[23:16] == OP_SETBG) begin
                            state_q <= ST_REG;
                        end else begin
                            pkt_err_q <= 1'b1;
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= word_data[ADDR_W-1:0];
                        if (rem_q != 16'd0) begin
                            state_q <= ST_DATA;
                        end else if (CHK_EN) begin
                            state_q <= ST_CHK;
                        end else begin
                            state_q    <= ST_IDLE;
                            pkt_done_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= addr_q;
                        fb_wdata_q <= word_data;
                        addr_q     <= addr_q + 1'b1;
                        rem_q      <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            if (CHK_EN) begin
                                state_q <= ST_CHK;
                            end else begin
                                state_q    <= ST_IDLE;
                                pkt_done_q <= 1'b1;
                            end
                        end
                    end
                    ST_REG: begin
                        // With a trailer the colour is held back until the checksum proves it good.
                        bg_pend_q     <= word_data;
                        bg_pend_q_vld <= 1'b1;
                        if (CHK_EN) begin
                            state_q <= ST_CHK;
                        end else begin
                            bg_color_q <= word_data;
                            state_q    <= ST_IDLE;
                            pkt_done_q <= 1'b1;
                        end
                    end
                    ST_CHK: begin
                        state_q <= ST_IDLE;
                        if (word_data == csum_q) begin
                            pkt_done_q <= 1'b1;
                            if (bg_pend_q_vld) begin
                                bg_color_q <= bg_pend_q;
                            end
                        end else begin
                            pkt_err_q <= 1'b1;
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (tmo_expire) begin
                state_q   <= ST_IDLE;
                pkt_err_q <= 1'b1;
                err_cnt_q <= sat_inc8(err_cnt_q);
            end
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign bg_color = bg_color_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_done = pkt_done_q;
    assign pkt_err  = pkt_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed table-driven bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    localparam int ADDR_W  = 17;
    localparam int TIMEOUT = 100;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [31:0]       word_data = '0;
    logic              word_valid = 1'b0;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [31:0]       fb_wdata;
    logic [31:0]       bg_color;
    logic              busy;
    logic              pkt_done;
    logic              pkt_err;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_data  (word_data),
        .word_valid (word_valid),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .bg_color   (bg_color),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic              v;
        logic [31:0]       d;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              done;
        logic              err;
        logic              busy;
        logic [31:0]       bg;
        logic [7:0]        ecnt;
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] csum;
    logic [31:0] bg_model;
    logic [7:0]  ecnt_model;
    int          cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents one input cycle and returns at the next negedge.
    task automatic drive(input logic v, input logic [31:0] d);
        word_valid = v;
        word_data  = d;
        @(negedge clk);
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic we,
                       input logic [ADDR_W-1:0] a, input logic done, input logic err,
                       input logic bsy);
        vec_t r;
        if (err) ecnt_model = ecnt_model + 8'd1;
        r.v = v; r.d = d; r.we = we; r.addr = a; r.done = done; r.err = err;
        r.busy = bsy; r.bg = bg_model; r.ecnt = ecnt_model;
        vecs.push_back(r);
    endtask

    initial begin
        ecnt_model = '0;
        bg_model   = '0;

        csum = 32'hA501_0003;         add(1, csum, 0, '0, 0, 0, 1);
        csum ^= 32'h0000_0010;        add(1, 32'h10, 0, '0, 0, 0, 1);
        csum ^= 32'h11;               add(1, 32'h11, 1, 17'h10, 0, 0, 1);
        csum ^= 32'h22;               add(1, 32'h22, 1, 17'h11, 0, 0, 1);
        csum ^= 32'h33;               add(1, 32'h33, 1, 17'h12, !CHK, 0, CHK);
        if (CHK)                      add(1, csum, 0, '0, 1, 0, 0);
        add(0, 32'h0, 0, '0, 0, 0, 0);
        add(1, 32'h5A01_0001, 0, '0, 0, 1, 0);
        add(1, 32'hA503_0000, 0, '0, 0, 1, 0);
        csum = 32'hA502_0000;         add(1, csum, 0, '0, 0, 0, 1);
        csum ^= 32'h00FF_00FF;
        if (!CHK) bg_model = 32'h00FF_00FF;
        add(1, 32'h00FF_00FF, 0, '0, !CHK, 0, CHK);
        if (CHK) begin
            bg_model = 32'h00FF_00FF;
            add(1, csum, 0, '0, 1, 0, 0);
        end
        csum = 32'hA501_0000;         add(1, csum, 0, '0, 0, 0, 1);
        csum ^= 32'h5;                add(1, 32'h5, 0, '0, !CHK, 0, CHK);
        if (CHK)                      add(1, csum, 0, '0, 1, 0, 0);
        add(0, 32'h0, 0, '0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_we",   fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_wdat", fb_wdata, 0);
        check("rst_bg",   bg_color, 0);
        check("rst_busy", busy, 0);
        check("rst_done", pkt_done, 0);
        check("rst_err",  pkt_err, 0);
        check("rst_ecnt", err_cnt, 0);
        rst_n = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d);
            check($sformatf("v%0d_we", i), fb_we, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("v%0d_addr", i), fb_addr, vecs[i].addr);
                check($sformatf("v%0d_wdata", i), fb_wdata, vecs[i].d);
            end
            check($sformatf("v%0d_done", i), pkt_done, vecs[i].done);
            check($sformatf("v%0d_err", i), pkt_err, vecs[i].err);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_bg", i), bg_color, vecs[i].bg);
            check($sformatf("v%0d_ecnt", i), err_cnt, vecs[i].ecnt);
        end

        // Address wrap at the top of the framebuffer
        csum = 32'hA501_0002; drive(1, csum);
        csum ^= 32'h0001_FFFF; drive(1, 32'h0001_FFFF);
        csum ^= 32'hAA; drive(1, 32'hAA);
        check("wrap_we0", fb_we, 1);
        check("wrap_addr0", fb_addr, 17'h1FFFF);
        csum ^= 32'hBB; drive(1, 32'hBB);
        check("wrap_we1", fb_we, 1);
        check("wrap_addr1", fb_addr, 0);
        check("wrap_wdata1", fb_wdata, 32'hBB);
        check("wrap_done", pkt_done, !CHK);
`ifdef UART_CMD_CHECKSUM_EN
        drive(1, csum);
        check("wrap_trl_done", pkt_done, 1);
`endif
        drive(0, 0);
        check("wrap_idle", busy, 0);

        // A word landing on the expiry cycle must keep the packet alive
        csum = 32'hA501_0001; drive(1, csum);
        repeat (TIMEOUT - 1) drive(0, 0);
        check("wins_pre_err", pkt_err, 0);
        check("wins_pre_busy", busy, 1);
        csum ^= 32'h20; drive(1, 32'h20);
        check("wins_err", pkt_err, 0);
        check("wins_busy", busy, 1);
        csum ^= 32'h77; drive(1, 32'h77);
        check("wins_we", fb_we, 1);
        check("wins_addr", fb_addr, 17'h20);
        check("wins_done", pkt_done, !CHK);
`ifdef UART_CMD_CHECKSUM_EN
        drive(1, csum);
        check("wins_trl_done", pkt_done, 1);
`endif
        drive(0, 0);

        // Stalled packet: abort after TIMEOUT idle cycles
        drive(1, 32'hA501_0004);
        drive(1, 32'h0);
        drive(1, 32'h1);
        check("tmo_we", fb_we, 1);
        cyc = 0;
        while (!pkt_err && cyc < 3 * TIMEOUT) begin
            drive(0, 0);
            cyc++;
        end
        ecnt_model = ecnt_model + 8'd1;
        check("tmo_cycles", cyc, TIMEOUT);
        check("tmo_busy", busy, 0);
        check("tmo_ecnt", err_cnt, ecnt_model);
        drive(0, 0);
        check("tmo_pulse", pkt_err, 0);

`ifdef UART_CMD_CHECKSUM_EN
        csum = 32'hA502_0000; drive(1, csum);
        csum ^= 32'h1234_5678; drive(1, 32'h1234_5678);
        check("bad_trl_bg_hold", bg_color, 32'h00FF_00FF);
        drive(1, csum ^ 32'h0000_0100);
        ecnt_model = ecnt_model + 8'd1;
        check("bad_trl_err", pkt_err, 1);
        check("bad_trl_done", pkt_done, 0);
        check("bad_trl_bg", bg_color, 32'h00FF_00FF);
        check("bad_trl_ecnt", err_cnt, ecnt_model);
        drive(0, 0);
`endif

        // Reset in the middle of a packet
        drive(1, 32'hA501_0005);
        drive(1, 32'h40);
        drive(1, 32'h99);
        rst_n = 1'b1;
        drive(0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", pkt_done, 0);
        check("mid_rst_err", pkt_err, 0);
        check("mid_rst_ecnt", err_cnt, 0);
        check("mid_rst_bg", bg_color, 0);
        rst_n = 1'b0;
        drive(1, 32'h0000_0055);
        check("post_rst_we", fb_we, 0);
        check("post_rst_err", pkt_err, 1);
        check("post_rst_ecnt", err_cnt, 1);

        // Error counter saturation with back-to-back bad words
        repeat (300) drive(1, 32'h5A00_0000);
        check("sat_err", pkt_err, 1);
        check("sat_ecnt", err_cnt, 8'd255);
        drive(0, 0);
        check("sat_hold", err_cnt, 8'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
